// File: rtl/adder_operand_loader.sv
// adder_operand_loader: assembles two ADDER_WIDTH-bit operands from a
// least-significant-word-first stream, issues them as registered a/b with a
// one-cycle op_valid strobe, and tracks the 2-edge adder latency in sum_valid.
module adder_operand_loader #(
  parameter int unsigned ADDER_WIDTH = 138,
  parameter int unsigned WORD_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   abort,
  output logic [ADDER_WIDTH-1:0] a,
  output logic [ADDER_WIDTH-1:0] b,
  output logic                   op_valid,
  output logic                   sum_valid,
  output logic [15:0]            pair_count
);

  localparam int unsigned WORDS   = (ADDER_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned PAD_W   = WORDS * WORD_WIDTH;
  localparam int unsigned CNT_W   = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {
    LOAD_A = 1'b0,
    LOAD_B = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ADDER_WIDTH-1:0] sha_q, sha_d;
  logic [ADDER_WIDTH-1:0] shb_q, shb_d;
  logic [ADDER_WIDTH-1:0] a_q, a_d;
  logic [ADDER_WIDTH-1:0] b_q, b_d;
  logic                   op_valid_q, op_valid_d;
  logic                   v1_q, v1_d;
  logic                   sum_valid_q, sum_valid_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   accept;
  logic                   last_word;

  // Write one word into its slice of a shadow operand; bits past ADDER_WIDTH fall off.
  function automatic logic [ADDER_WIDTH-1:0] merge_word(
    input logic [ADDER_WIDTH-1:0] shadow,
    input logic [IDX_W-1:0]       idx,
    input logic [WORD_WIDTH-1:0]  word
  );
    logic [PAD_W-1:0] pad;
    int unsigned      base;
    pad  = PAD_W'(shadow);
    base = 32'(idx) * WORD_WIDTH;
    pad[base +: WORD_WIDTH] = word;
    return ADDER_WIDTH'(pad);
  endfunction

  // Ready whenever not in reset and not discarding; no gaps between pairs.
  assign in_ready  = ~reset & ~abort;
  assign accept    = in_valid & in_ready;
  assign last_word = (idx_q == LAST_IDX);

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD_A;
      idx_q       <= '0;
      sha_q       <= '0;
      shb_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_valid_q  <= 1'b0;
      v1_q        <= 1'b0;
      sum_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sha_q       <= sha_d;
      shb_q       <= shb_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_valid_q  <= op_valid_d;
      v1_q        <= v1_d;
      sum_valid_q <= sum_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state: load slices, issue on the final B word, abort resets the load position.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sha_d       = sha_q;
    shb_d       = shb_q;
    a_d         = a_q;
    b_d         = b_q;
    op_valid_d  = 1'b0;
    cnt_d       = cnt_q;
    v1_d        = op_valid_q;
    sum_valid_d = v1_q;

    if (abort) begin
      state_d = LOAD_A;
      idx_d   = '0;
    end else if (accept) begin
      unique case (state_q)
        LOAD_A: begin
          sha_d = merge_word(sha_q, idx_q, in_data);
          if (last_word) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        LOAD_B: begin
          shb_d = merge_word(shb_q, idx_q, in_data);
          if (last_word) begin
            a_d        = sha_q;
            b_d        = merge_word(shb_q, idx_q, in_data);
            op_valid_d = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            idx_d      = '0;
            state_d    = LOAD_A;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      endcase
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign op_valid   = op_valid_q;
  assign sum_valid  = sum_valid_q;
  assign pair_count = cnt_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Scoreboard bench for adder_operand_loader: expected issues are queued at
// stimulus time and popped by a monitor whenever op_valid is seen.
module tb_adder_operand_loader;

  localparam int unsigned AW = 138;
  localparam int unsigned WW = 32;

  logic          clk;
  logic          reset;
  logic [WW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          abort;
  logic [AW-1:0] a;
  logic [AW-1:0] b;
  logic          op_valid;
  logic          sum_valid;
  logic [15:0]   pair_count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [15:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   pulses     = 0;
  int   exp_pulses = 0;
  logic [15:0] exp_cnt = 16'd0;

  adder_operand_loader #(.ADDER_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .abort      (abort),
    .a          (a),
    .b          (b),
    .op_valid   (op_valid),
    .sum_valid  (sum_valid),
    .pair_count (pair_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Pack A and B into the 10-word stream, each operand zero-padded to 160 bits.
  function automatic logic [319:0] mk(input logic [AW-1:0] av, input logic [AW-1:0] bv);
    return {22'b0, bv, 22'b0, av};
  endfunction

  task automatic push_exp(input logic [AW-1:0] av, input logic [AW-1:0] bv);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.a = av;
    e.b = bv;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
    exp_pulses++;
  endtask

  // Drive n words; with stall, one idle cycle precedes each word. Leaves in_valid high.
  task automatic send_words(input logic [319:0] w, input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = w[i*32 +: 32];
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pop and compare an expected issue on every op_valid cycle.
  always @(negedge clk) begin
    if (op_valid === 1'b1) begin
      exp_t e;
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_op_valid actual=1 required=0 count=%0d", pair_count);
      end else begin
        e = exp_q.pop_front();
        chk("mon_a", a, e.a);
        chk("mon_b", b, e.b);
        chk("mon_pair_count", AW'(pair_count), AW'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [319:0] w;
  logic [AW-1:0] a3, b3;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    abort    = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", AW'(in_ready), AW'(0));
    chk("rst_a", a, '0);
    chk("rst_b", b, '0);
    chk("rst_op_valid", AW'(op_valid), AW'(0));
    chk("rst_sum_valid", AW'(sum_valid), AW'(0));
    chk("rst_pair_count", AW'(pair_count), AW'(0));
    reset = 1'b0;
    #1;
    chk("in_ready_idle", AW'(in_ready), AW'(1));

    // Basic pair A=1, B=2 with sum_valid latency.
    push_exp(AW'(1), AW'(2));
    send_words(mk(AW'(1), AW'(2)), 10, 1'b0);
    in_valid = 1'b0;
    chk("t1_op_valid", AW'(op_valid), AW'(1));
    chk("t1_a", a, AW'(1));
    chk("t1_b", b, AW'(2));
    chk("t1_count", AW'(pair_count), AW'(1));
    @(posedge clk); #1;
    chk("t1_op_valid_drop", AW'(op_valid), AW'(0));
    chk("t1_sum_valid_early", AW'(sum_valid), AW'(0));
    @(posedge clk); #1;
    chk("t1_sum_valid", AW'(sum_valid), AW'(1));
    @(posedge clk); #1;
    chk("t1_sum_valid_drop", AW'(sum_valid), AW'(0));

    // Junk upper bits in the final words must be dropped.
    w = mk('0, '0);
    w[4*32 +: 32] = 32'hFFFF_FFFF;
    w[9*32 +: 32] = 32'hFFFF_FC00;
    push_exp({10'h3FF, 128'h0}, '0);
    send_words(w, 10, 1'b0);
    in_valid = 1'b0;
    chk("t2_a", a, {10'h3FF, 128'h0});
    chk("t2_b", b, '0);

    // Stalled pair: in_valid toggles every cycle.
    a3 = {10'h2AB, 128'h0123456789ABCDEF_FEDCBA9876543210};
    b3 = {10'h155, 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0};
    push_exp(a3, b3);
    send_words(mk(a3, b3), 10, 1'b1);
    in_valid = 1'b0;
    chk("t3_op_valid", AW'(op_valid), AW'(1));
    chk("t3_a", a, a3);
    chk("t3_b", b, b3);

    // Abort after 3 A words, then clean pair A=5, B=7.
    send_words({320{1'b1}}, 3, 1'b0);
    in_valid = 1'b0;
    abort    = 1'b1;
    #1;
    chk("t4_in_ready_abort", AW'(in_ready), AW'(0));
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t4_a_hold", a, a3);
    chk("t4_b_hold", b, b3);
    push_exp(AW'(5), AW'(7));
    send_words(mk(AW'(5), AW'(7)), 10, 1'b0);
    in_valid = 1'b0;
    chk("t4_a", a, AW'(5));
    chk("t4_b", b, AW'(7));

    // Abort concurrent with the final B word: no issue, restart at A word 0.
    w = mk(AW'(9), AW'(9));
    send_words(w, 9, 1'b0);
    in_data  = w[9*32 +: 32];
    in_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("t5_no_op_valid", AW'(op_valid), AW'(0));
    chk("t5_count", AW'(pair_count), AW'(4));
    push_exp(AW'(17), AW'(34));
    send_words(mk(AW'(17), AW'(34)), 10, 1'b0);
    in_valid = 1'b0;
    chk("t5_a", a, AW'(17));
    chk("t5_b", b, AW'(34));
    chk("t5_count_after", AW'(pair_count), AW'(5));
    @(posedge clk); @(posedge clk); @(posedge clk); #1;

    // Fresh reset, three gapless pairs, then reset one cycle after the third issue.
    reset = 1'b1;
    exp_cnt = 16'd0;
    #1;
    chk("t6_rst_count", AW'(pair_count), AW'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    push_exp(AW'(1), AW'(1));
    push_exp(AW'(2), AW'(3));
    push_exp(AW'(4), AW'(5));
    send_words(mk(AW'(1), AW'(1)), 10, 1'b0);
    send_words(mk(AW'(2), AW'(3)), 10, 1'b0);
    send_words(mk(AW'(4), AW'(5)), 10, 1'b0);
    in_valid = 1'b0;
    chk("t6_op_valid", AW'(op_valid), AW'(1));
    chk("t6_count3", AW'(pair_count), AW'(3));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t6_in_ready_rst", AW'(in_ready), AW'(0));
    chk("t6_count_rst", AW'(pair_count), AW'(0));
    chk("t6_a_rst", a, '0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("t6_sum_valid_in_rst", AW'(sum_valid), AW'(0));
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t6_sum_valid_after", AW'(sum_valid), AW'(0));
    end

    chk("op_valid_pulses", AW'(pulses), AW'(exp_pulses));
    chk("queue_drained", AW'(exp_q.size()), AW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
